// File: rtl/commit_checker_pkg.sv
// Shared types for the commit checker: golden record layout, FSM states and
// mismatch-mask bit positions.
package commit_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  Ard;
      logic [31:0] data;
   } commit_rec_t;

   localparam int REC_W = $bits(commit_rec_t);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_RUN,
      ST_PASS,
      ST_FAIL
   } chk_state_e;

   localparam int MASK_PC   = 3;
   localparam int MASK_INST = 2;
   localparam int MASK_ARD  = 1;
   localparam int MASK_DATA = 0;

endpackage

// File: rtl/commit_rec_cmp.sv
// Combinational golden-vs-retired record compare producing the 4-bit field
// mismatch mask.
module commit_rec_cmp
   import commit_pkg::*;
(
   input  logic [REC_W-1:0] golden,
   input  logic [REC_W-1:0] actual,
   output logic [3:0]       mask
);

   commit_rec_t g;
   commit_rec_t a;

   assign g = commit_rec_t'(golden);
   assign a = commit_rec_t'(actual);

   always_comb begin
      mask            = 4'b0000;
      mask[MASK_PC]   = (g.pc   != a.pc);
      mask[MASK_INST] = (g.inst != a.inst);
      mask[MASK_ARD]  = (g.Ard  != a.Ard);
      // Writeback data is meaningless when the golden record writes x0.
      mask[MASK_DATA] = (g.Ard != 5'd0) && (g.data != a.data);
   end

endmodule

// File: rtl/commit_checker.sv
// Holds a golden commit trace and replays it against the live ROB commit
// stream, latching the first divergence.
module commit_checker
   import commit_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDXW  = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic [31:0]     load_pc,
   input  logic [31:0]     load_inst,
   input  logic [4:0]      load_Ard,
   input  logic [31:0]     load_data,
   input  logic            start,
   input  logic            commit_valid,
   input  logic [31:0]     commit_pc,
   input  logic [31:0]     commit_inst,
   input  logic [4:0]      commit_Ard,
   input  logic [31:0]     commit_data,
   output logic            busy,
   output logic            pass,
   output logic            fail,
   output logic [IDXW-1:0] fail_idx,
   output logic [3:0]      fail_mask,
   output logic [IDXW:0]   match_count
);

   localparam logic [IDXW:0] DEPTH_P = (IDXW+1)'(DEPTH);

   chk_state_e      state;
   logic [IDXW:0]   wr_ptr;
   logic [IDXW-1:0] rd_ptr;
   commit_rec_t     mem [DEPTH];

   logic             load_fire;
   logic [REC_W-1:0] golden_vec;
   logic [REC_W-1:0] actual_vec;
   logic [3:0]       mask;
   logic             last_rec;

   assign load_ready = (state == ST_LOAD) && (wr_ptr < DEPTH_P);
   assign load_fire  = load_valid && load_ready;
   assign golden_vec = mem[rd_ptr];
   assign actual_vec = {commit_pc, commit_inst, commit_Ard, commit_data};
   assign last_rec   = ({1'b0, rd_ptr} == (wr_ptr - 1'b1));

   commit_rec_cmp u_cmp (
      .golden (golden_vec),
      .actual (actual_vec),
      .mask   (mask)
   );

   // Trace storage is deliberately not reset so it survives a core reset.
   always_ff @(posedge clk) begin
      if (load_fire && !clear) begin
         mem[wr_ptr[IDXW-1:0]] <= {load_pc, load_inst, load_Ard, load_data};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_LOAD;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         match_count <= '0;
         fail_idx    <= '0;
         fail_mask   <= 4'b0000;
         busy        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
      end else if (clear) begin
         state       <= ST_LOAD;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         match_count <= '0;
         fail_idx    <= '0;
         fail_mask   <= 4'b0000;
         busy        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (load_fire) begin
                  wr_ptr <= wr_ptr + 1'b1;
               end
               // A record accepted alongside start is part of the trace.
               if (start && ((wr_ptr != '0) || load_fire)) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (commit_valid) begin
                  if (mask != 4'b0000) begin
                     state     <= ST_FAIL;
                     busy      <= 1'b0;
                     fail      <= 1'b1;
                     fail_idx  <= rd_ptr;
                     fail_mask <= mask;
                  end else begin
                     match_count <= match_count + 1'b1;
                     if (last_rec) begin
                        state <= ST_PASS;
                        busy  <= 1'b0;
                        pass  <= 1'b1;
                     end else begin
                        rd_ptr <= rd_ptr + 1'b1;
                     end
                  end
               end
            end
            ST_PASS: begin
               // Anything retiring past the end of the trace is an extra commit.
               if (commit_valid) begin
                  state     <= ST_FAIL;
                  pass      <= 1'b0;
                  fail      <= 1'b1;
                  fail_idx  <= wr_ptr[IDXW-1:0];
                  fail_mask <= 4'b0000;
               end
            end
            default: begin
               state <= ST_FAIL;
            end
         endcase
      end
   end

endmodule

// File: doc/commit_checker.md
Name: commit_checker

Overview:
- Consumer-side counterpart of the commit logging path: accepts a golden commit trace of {pc, inst, Ard, data} records, then replays it against the live commit stream from the ROB commit port.
- Flags the first divergence and reports which record and which fields differ.
- Synthesizable and placed beside the core top, so FPGA and emulation runs get self-checking without file I/O.

Parameters:
- DEPTH, 64, number of golden records held (power of two, at least 2).
- IDXW, $clog2(DEPTH), width of record index.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- clear  in  1  synchronous: return to LOAD and empty the trace
- load_valid  in  1  golden record present
- load_ready  out  1  checker can accept a record
- load_pc  in  32  golden PC
- load_inst  in  32  golden instruction
- load_Ard  in  5  golden architectural rd
- load_data  in  32  golden writeback data
- start  in  1  end of loading; begin checking
- commit_valid  in  1  core retired an instruction this cycle
- commit_pc  in  32  retired PC
- commit_inst  in  32  retired instruction
- commit_Ard  in  5  retired rd
- commit_data  in  32  retired writeback data
- busy  out  1  state is RUN
- pass  out  1  all records matched, sticky
- fail  out  1  divergence detected, sticky
- fail_idx  out  IDXW  record index of first failure
- fail_mask  out  4  bit3 pc, bit2 inst, bit1 Ard, bit0 data mismatch; 0000 means an extra commit arrived
- match_count  out  IDXW+1  commits matched so far

Behaviour:
- Reset (rst=0, asynchronous):
  - State = LOAD.
  - Write pointer, read pointer, match_count and fail_idx = 0.
  - fail_mask = 0000.
  - busy, pass and fail = 0.
  - Golden memory contents are not reset.
- Outputs: all status outputs are registered. load_ready is combinational: (state==LOAD) && (wr_ptr < DEPTH).
- States: LOAD, RUN, PASS, FAIL.
- LOAD:
  - Each cycle with load_valid && load_ready: write the record at wr_ptr, then wr_ptr++.
  - wr_ptr is IDXW+1 bits. When wr_ptr==DEPTH, load_ready=0 and further load_valid is ignored.
  - start with wr_ptr>0: go to RUN next cycle.
  - start with wr_ptr==0: ignored.
  - commit_valid is ignored in LOAD.
  - load_valid && load_ready in the same cycle as start: the record is written and counts toward the trace.
- RUN:
  - Each commit_valid compares against mem[rd_ptr] through a combinational array read. Outcome is visible the next cycle (1-cycle latency).
  - Mask bits: pc !=, inst !=, Ard !=, and data != only when golden Ard != 0. With golden Ard == 0, the data bit is always 0.
  - Nonzero mask: go to FAIL; fail_idx = rd_ptr; fail_mask = mask.
  - Zero mask: match_count++ and rd_ptr++. If rd_ptr == wr_ptr-1, go to PASS.
  - Cycles without commit_valid: no state change.
- PASS:
  - pass=1.
  - Any commit_valid: go to FAIL; fail_idx = wr_ptr truncated to IDXW; fail_mask = 0000. pass drops to 0 in the same cycle fail rises.
- FAIL: terminal. All fail_* fields hold; further commits are ignored.
- clear:
  - From any state: go to LOAD next cycle. Clears wr_ptr, rd_ptr, match_count, fail_idx, fail_mask, pass and fail.
  - clear beats start, load_valid and commit_valid in the same cycle.
- Wrap-around: none. rd_ptr never exceeds wr_ptr-1, and wr_ptr saturates at DEPTH.
- One commit per cycle maximum. The core commit width is 1.

Decomposition:
- Shared package (commit_pkg) holds:
  - commit_rec_t struct {pc[31:0], inst[31:0], Ard[4:0], data[31:0]}.
  - State enum chk_state_e.
  - Mask bit position constants MASK_PC=3, MASK_INST=2, MASK_ARD=1, MASK_DATA=0.
- One sub-module: commit_rec_cmp, a combinational record compare that produces the 4-bit mask and applies the Ard==0 rule. The golden memory is an in-module register array.

Test Plan:
- Load 3 records: {0x0,0x00500093,1,5}, {0x4,0x00108113,2,6}, {0x8,0x00000013,0,0xDEAD}. start. Commit identical values, except record 2 data=0x1234 -> pass=1 one cycle after the 3rd commit; match_count=3; fail=0. Checks the Ard==0 data skip.
- Same trace; 2nd commit with pc=0x8 and data=7 -> fail=1, fail_idx=1, fail_mask=1001, match_count=1. A later commit leaves all fail_* unchanged.
- Pass case above, then one extra commit -> fail=1, pass=0, fail_mask=0000, fail_idx=3.
- Hold load_valid for 70 cycles with DEPTH=64 -> load_ready low after 64 accepts. start; 64 matching commits -> pass=1, match_count=64.
- start with empty trace -> stays in LOAD, busy=0. Then load_valid together with start in one cycle -> record written, RUN entered, busy=1 next cycle.
- rst low mid-RUN after 2 of 3 matches -> all outputs 0 immediately (asynchronous). clear asserted in FAIL together with start -> LOAD, fail=0, load_ready=1.
